// File: rtl/atm_pkg.sv
// atm_pkg -- shared definitions for the ATM account arbiter.
//   Default parameter values, the opcode / status / FSM state encodings and
//   the account-index width used on the init and per-terminal index ports.
package atm_pkg;

  localparam int NREQ_DEF  = 4;   // terminal requesters
  localparam int DEPTH_DEF = 3;   // accounts
  localparam int BAL_W_DEF = 12;  // balance width
  localparam int AMT_W_DEF = 6;   // amount width
  localparam int IDX_W     = 2;   // account index width on every port

  typedef enum logic [1:0] {
    OP_BALANCE  = 2'b00,
    OP_DEPOSIT  = 2'b01,
    OP_WITHDRAW = 2'b10,
    OP_TRANSFER = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK           = 2'b00,
    ST_INSUFFICIENT = 2'b01,
    ST_BAD_ACCT     = 2'b10,
    ST_OVERFLOW     = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CHECK = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/atm_rr_arbiter.sv
// atm_rr_arbiter -- combinational round-robin grant selection.
//   req   in  NREQ   pending requests
//   ptr   in  PTR_W  highest-priority requester index
//   grant out NREQ   one-hot grant (all zero when no request is pending)
module atm_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  // Scan from ptr upward, wrapping; the first pending request wins.
  always_comb begin
    logic found;
    int   idx;
    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it holding its old value (which would infer a latch).
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/atm_db_arbiter.sv
// atm_db_arbiter -- shared account store serving NREQ ATM terminals.
//   One transaction at a time walks IDLE -> READ -> CHECK -> WRITE -> RESP.
//   Ports:
//     clk, rst              clock; asynchronous active-high reset
//     req[NREQ]             per-terminal request, held until done
//     op, src_idx, dst_idx  2 bits per terminal (opcode, account indices)
//     amount                AMT_W bits per terminal, unsigned
//     init_we/idx/bal       load one account balance while IDLE
//     gnt[NREQ]             one-hot grant, high for the whole transaction
//     done[NREQ]            one-cycle completion pulse (RESP cycle)
//     status, bal_out       result, valid with done
//     busy                  FSM not in IDLE
module atm_db_arbiter
  import atm_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int BAL_W = BAL_W_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [2*NREQ-1:0]     src_idx,
  input  logic [2*NREQ-1:0]     dst_idx,
  input  logic [AMT_W*NREQ-1:0] amount,
  input  logic                  init_we,
  input  logic [IDX_W-1:0]      init_idx,
  input  logic [BAL_W-1:0]      init_bal,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [1:0]            status,
  output logic [BAL_W-1:0]      bal_out,
  output logic                  busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gidx_q;

  // Operands latched at grant time; the terminal may change its inputs after.
  op_e                op_q;
  logic [IDX_W-1:0]   src_q;
  logic [IDX_W-1:0]   dst_q;
  logic [AMT_W-1:0]   amt_q;

  logic [BAL_W-1:0]   src_bal_q;
  logic [BAL_W-1:0]   dst_bal_q;
  logic [BAL_W-1:0]   res_src_q;
  logic [BAL_W-1:0]   res_dst_q;
  status_e            st_q;

  logic [BAL_W-1:0]   bal_mem [DEPTH];

  // ---------------------------------------------------------------- grant
  logic [NREQ-1:0]    grant_c;
  logic [PTR_W-1:0]   grant_idx_c;

  atm_rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (grant_c)
  );

  always_comb begin
    grant_idx_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_c[i]) grant_idx_c = PTR_W'(i);
    end
  end

  // --------------------------------------------------------- check logic
  logic               src_ok_c;
  logic               dst_ok_c;
  logic               bad_c;
  logic [BAL_W-1:0]   amt_ext_c;
  logic [BAL_W:0]     src_sum_c;
  logic [BAL_W:0]     dst_sum_c;
  logic               insuf_c;
  status_e            chk_st_c;
  logic [BAL_W-1:0]   chk_src_c;
  logic [BAL_W-1:0]   chk_dst_c;

  assign src_ok_c  = int'(src_q) < DEPTH;
  assign dst_ok_c  = int'(dst_q) < DEPTH;
  // dst only matters for TRANSFER; other opcodes ignore it entirely.
  assign bad_c     = !src_ok_c ||
                     ((op_q == OP_TRANSFER) && (!dst_ok_c || (dst_q == src_q)));
  assign amt_ext_c = BAL_W'(amt_q);
  assign src_sum_c = {1'b0, src_bal_q} + {1'b0, amt_ext_c};
  assign dst_sum_c = {1'b0, dst_bal_q} + {1'b0, amt_ext_c};
  assign insuf_c   = amt_ext_c > src_bal_q;

  always_comb begin
    chk_st_c  = ST_OK;
    chk_src_c = src_bal_q;
    chk_dst_c = dst_bal_q;
    if (bad_c) begin
      chk_st_c  = ST_BAD_ACCT;
      chk_src_c = '0;
    end else begin
      unique case (op_q)
        OP_BALANCE: ;
        OP_DEPOSIT: begin
          if (src_sum_c[BAL_W]) chk_st_c  = ST_OVERFLOW;
          else                  chk_src_c = src_sum_c[BAL_W-1:0];
        end
        OP_WITHDRAW: begin
          if (insuf_c) chk_st_c  = ST_INSUFFICIENT;
          else         chk_src_c = src_bal_q - amt_ext_c;
        end
        OP_TRANSFER: begin
          if (insuf_c) begin
            chk_st_c = ST_INSUFFICIENT;
          end else if (dst_sum_c[BAL_W]) begin
            chk_st_c = ST_OVERFLOW;
          end else begin
            chk_src_c = src_bal_q - amt_ext_c;
            chk_dst_c = dst_sum_c[BAL_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------ FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gidx_q    <= '0;
      op_q      <= OP_BALANCE;
      src_q     <= '0;
      dst_q     <= '0;
      amt_q     <= '0;
      src_bal_q <= '0;
      dst_bal_q <= '0;
      res_src_q <= '0;
      res_dst_q <= '0;
      st_q      <= ST_OK;
      gnt       <= '0;
      done      <= '0;
      status    <= '0;
      bal_out   <= '0;
      busy      <= 1'b0;
      // NOTE: the account array is reset too -- balances must read 0 after
      // reset, and at DEPTH entries this stays a handful of flops.
      for (int a = 0; a < DEPTH; a++) bal_mem[a] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (init_we) begin
            if (int'(init_idx) < DEPTH) bal_mem[init_idx] <= init_bal;
          end else if (|req) begin
            gnt    <= grant_c;
            gidx_q <= grant_idx_c;
            op_q   <= op_e'(op[2*grant_idx_c +: 2]);
            src_q  <= src_idx[2*grant_idx_c +: 2];
            dst_q  <= dst_idx[2*grant_idx_c +: 2];
            amt_q  <= amount[AMT_W*grant_idx_c +: AMT_W];
            busy   <= 1'b1;
            state  <= S_READ;
          end
        end
        S_READ: begin
          src_bal_q <= src_ok_c ? bal_mem[src_q] : '0;
          dst_bal_q <= dst_ok_c ? bal_mem[dst_q] : '0;
          state     <= S_CHECK;
        end
        S_CHECK: begin
          st_q      <= chk_st_c;
          res_src_q <= chk_src_c;
          res_dst_q <= chk_dst_c;
          state     <= S_WRITE;
        end
        S_WRITE: begin
          if (st_q == ST_OK) begin
            if (op_q == OP_DEPOSIT || op_q == OP_WITHDRAW) begin
              bal_mem[src_q] <= res_src_q;
            end else if (op_q == OP_TRANSFER) begin
              bal_mem[src_q] <= res_src_q;
              bal_mem[dst_q] <= res_dst_q;
            end
          end
          done    <= gnt;
          status  <= st_q;
          bal_out <= res_src_q;
          state   <= S_RESP;
        end
        S_RESP: begin
          done    <= '0;
          gnt     <= '0;
          status  <= '0;
          bal_out <= '0;
          busy    <= 1'b0;
          ptr     <= (gidx_q == PTR_W'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/atm_db_arbiter.md
ATM_DB_ARBITER -- requirements
Module: atm_db_arbiter

Interface
REQ-001 The block SHALL have parameters NREQ, default 4, number of terminal requesters.
REQ-002 The block SHALL have parameters DEPTH, default 3, number of accounts; BAL_W, default 12, balance width; AMT_W, default 6, amount width.
REQ-003 Ports SHALL be: clk  in  1  sole clock; rst  in  1  reset, asynchronous, active-high.
REQ-004 req  in  NREQ  per-terminal transaction request, held high until that terminal's done.
REQ-005 op  in  2*NREQ  per-terminal opcode: 00 BALANCE, 01 DEPOSIT, 10 WITHDRAW, 11 TRANSFER.
REQ-006 src_idx, dst_idx  in  2*NREQ each  per-terminal source and destination account index.
REQ-007 amount  in  AMT_W*NREQ  per-terminal unsigned amount.
REQ-008 init_we  in  1, init_idx  in  2, init_bal  in  BAL_W  configuration load of one account balance.
REQ-009 gnt  out  NREQ  one-hot grant, high for the whole transaction.
REQ-010 done  out  NREQ  one-cycle completion pulse to the granted terminal.
REQ-011 status  out  2, valid with done: 00 OK, 01 INSUFFICIENT, 10 BAD_ACCT, 11 OVERFLOW.
REQ-012 bal_out  out  BAL_W, valid with done: resulting source balance. busy  out  1: state not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, READ, CHECK, WRITE, RESP; each non-IDLE state lasts exactly one cycle, in that order, then back to IDLE.
REQ-014 In IDLE with init_we high, the block SHALL write init_bal to account init_idx (ignored if init_idx >= DEPTH), grant nothing, and stay in IDLE; init_we outside IDLE SHALL be ignored.
REQ-015 In IDLE with init_we low and any req high, the block SHALL grant one requester round-robin starting from pointer, set gnt, latch its operands, and go to READ.
REQ-016 After each RESP, pointer SHALL become (granted index + 1) mod NREQ.
REQ-017 done SHALL be high in the 4th cycle after the granting edge; gnt SHALL drop on the edge leaving RESP.
REQ-018 A req still high in IDLE after done SHALL be treated as a new transaction.
REQ-019 READ SHALL latch src and dst balances; CHECK SHALL compute result and status; WRITE SHALL update the account array only when status is OK.
REQ-020 Any src_idx >= DEPTH, or for TRANSFER any dst_idx >= DEPTH or dst_idx == src_idx, SHALL give BAD_ACCT, no write, bal_out 0.
REQ-021 BALANCE SHALL give OK, no write, bal_out = src balance.
REQ-022 DEPOSIT SHALL add amount zero-extended to BAL_W; a carry out of BAL_W SHALL give OVERFLOW, no write, bal_out unchanged balance.
REQ-023 WITHDRAW with amount > balance SHALL give INSUFFICIENT, no write, bal_out unchanged; otherwise it SHALL subtract amount.
REQ-024 TRANSFER SHALL check src as WITHDRAW, then dst as DEPOSIT (dst overflow gives OVERFLOW); on OK both accounts SHALL be written in the same WRITE cycle.
REQ-025 amount 0 SHALL be legal and give OK with unchanged balances.
REQ-026 req dropping mid-transaction SHALL NOT abort it; the transaction completes and done still pulses.

Reset
REQ-027 rst high SHALL force state IDLE, pointer 0, all balances 0, and gnt, done, status, bal_out, busy all 0, immediately and asynchronously.
REQ-028 Reset mid-transaction SHALL discard it with no partial write.

Structure
REQ-029 Opcode, status and state encodings and default widths SHALL live in the shared package atm_pkg.
REQ-030 Grant selection SHALL be the sub-module atm_rr_arbiter, combinational: inputs req and pointer, output one-hot grant.

Verification
REQ-031 init acct0=100, acct1=5; T0 DEPOSIT acct0 amount 20 -> done[0] in 4th cycle, status OK, bal_out 120.
REQ-032 acct1=5; T1 WITHDRAW acct1 amount 6 -> INSUFFICIENT, bal_out 5, acct1 still 5 on a following BALANCE.
REQ-033 acct0=100, acct2=0; T2 TRANSFER 0->2 amount 30 -> OK, bal_out 70, then BALANCE acct2 returns 30.
REQ-034 All four req held high from reset -> grants in order T0,T1,T2,T3,T0, each separated by 5 cycles.
REQ-035 acct0=4090; DEPOSIT amount 10 -> OVERFLOW, bal_out 4090; TRANSFER src_idx=dst_idx=1 -> BAD_ACCT, bal_out 0.
REQ-036 rst pulsed in WRITE cycle of a DEPOSIT -> all outputs 0 at once, next BALANCE returns 0.
